// File: rtl/game_pkg.sv
// Shared game types: screen state encoding, coordinate type, default arena and colours,
// plus the one-axis bounce step used by every moving obstacle.
package game_pkg;

  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  typedef logic [11:0] coord_t;

  localparam int unsigned DefArenaLeft   = 312;
  localparam int unsigned DefArenaRight  = 712;
  localparam int unsigned DefArenaTop    = 234;
  localparam int unsigned DefArenaBottom = 634;
  localparam logic [11:0] ColorWhite     = 12'hfff;

  typedef struct packed {
    coord_t pos;
    logic   flip;
  } step_t;

  // Signed arithmetic so a step below the low wall cannot wrap to a huge coordinate.
  function automatic step_t bounce_step(input coord_t pos, input logic neg,
                                        input int unsigned speed, input int unsigned lo,
                                        input int unsigned hi, input int unsigned size);
    logic signed [13:0] n;
    step_t              s;
    n = neg ? $signed({2'b00, pos}) - $signed(14'(speed))
            : $signed({2'b00, pos}) + $signed(14'(speed));
    s.flip = 1'b1;
    if (n < $signed(14'(lo))) begin
      s.pos = coord_t'(lo);
    end else if (n + $signed(14'(size)) > $signed(14'(hi))) begin
      s.pos = coord_t'(hi - size);
    end else begin
      s.pos  = n[11:0];
      s.flip = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/obstacle_mover.sv
// One obstacle: holds position and direction, reloads on i_load and takes one bounce
// step per i_step strobe.
module obstacle_mover
  import game_pkg::*;
#(
  parameter int unsigned SPEED        = 2,
  parameter int unsigned OBST_W       = 40,
  parameter int unsigned OBST_H       = 40,
  parameter int unsigned ARENA_LEFT   = DefArenaLeft,
  parameter int unsigned ARENA_RIGHT  = DefArenaRight,
  parameter int unsigned ARENA_TOP    = DefArenaTop,
  parameter int unsigned ARENA_BOTTOM = DefArenaBottom
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_load,
  input  logic   i_step,
  input  coord_t i_start_x,
  input  coord_t i_start_y,
  input  logic   i_start_dx_neg,
  input  logic   i_start_dy_neg,
  output coord_t o_x,
  output coord_t o_y
);

  coord_t r_x, r_y;
  logic   r_dx_neg, r_dy_neg;
  step_t  w_sx, w_sy;

  assign w_sx = bounce_step(r_x, r_dx_neg, SPEED, ARENA_LEFT, ARENA_RIGHT, OBST_W);
  assign w_sy = bounce_step(r_y, r_dy_neg, SPEED, ARENA_TOP, ARENA_BOTTOM, OBST_H);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
    end else if (i_load) begin
      r_x      <= i_start_x;
      r_y      <= i_start_y;
      r_dx_neg <= i_start_dx_neg;
      r_dy_neg <= i_start_dy_neg;
    end else if (i_step) begin
      r_x      <= w_sx.pos;
      r_y      <= w_sy.pos;
      r_dx_neg <= r_dx_neg ^ w_sx.flip;
      r_dy_neg <= r_dy_neg ^ w_sy.flip;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/obstacle_bouncer.sv
// Draws N_OBST bouncing rectangles over the VGA stream with one cycle of latency and
// reports the covered pixel and lowest covering obstacle index.
module obstacle_bouncer
  import game_pkg::*;
#(
  parameter int unsigned N_OBST       = 4,
  parameter int unsigned OBST_W       = 40,
  parameter int unsigned OBST_H       = 40,
  parameter int unsigned ARENA_LEFT   = DefArenaLeft,
  parameter int unsigned ARENA_RIGHT  = DefArenaRight,
  parameter int unsigned ARENA_TOP    = DefArenaTop,
  parameter int unsigned ARENA_BOTTOM = DefArenaBottom,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SPACING      = 90,
  parameter logic [11:0] COLOR        = ColorWhite
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic        play_selected,
  input  logic        pause,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        obstacle_hit,
  output logic [3:0]  obstacle_id
);

  state_e            r_state, w_state_nxt;
  logic              w_enter, w_leave, w_step, w_load, w_hit, w_draw;
  logic [3:0]        w_id;
  logic [N_OBST-1:0] w_inside;
  coord_t            w_x [N_OBST];
  coord_t            w_y [N_OBST];

  assign w_enter = (game_on | play_selected) & ~menu_on;
  assign w_leave = menu_on | ~play_selected;
  assign w_load  = (r_state == StInit);
  // r_vblnk doubles as vblnk_out, so the edge is seen against last cycle's blanking.
  assign w_step  = (r_state == StRun) & ~pause & vblnk_in & ~vblnk_out;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_enter) w_state_nxt = StInit;
      StInit:  w_state_nxt = StRun;
      StRun:   if (w_leave) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  for (genvar i = 0; i < N_OBST; i++) begin : g_obst
    obstacle_mover #(
      .SPEED(SPEED), .OBST_W(OBST_W), .OBST_H(OBST_H),
      .ARENA_LEFT(ARENA_LEFT), .ARENA_RIGHT(ARENA_RIGHT),
      .ARENA_TOP(ARENA_TOP), .ARENA_BOTTOM(ARENA_BOTTOM)
    ) u_mover (
      .i_clk          (pclk),
      .i_rst          (rst),
      .i_load         (w_load),
      .i_step         (w_step),
      .i_start_x      (coord_t'(ARENA_LEFT + i * SPACING)),
      .i_start_y      (coord_t'(ARENA_TOP)),
      .i_start_dx_neg (1'((i % 2) == 1)),
      .i_start_dy_neg (1'b0),
      .o_x            (w_x[i]),
      .o_y            (w_y[i])
    );

    assign w_inside[i] = (hcount_in >= w_x[i]) &&
                         ({1'b0, hcount_in} < {1'b0, w_x[i]} + 13'(OBST_W)) &&
                         (vcount_in >= w_y[i]) &&
                         ({1'b0, vcount_in} < {1'b0, w_y[i]} + 13'(OBST_H));
  end

  // Scan from the top index down so the lowest covering obstacle is written last.
  always_comb begin
    w_hit = 1'b0;
    w_id  = '0;
    for (int i = N_OBST - 1; i >= 0; i--) begin
      if (w_inside[i]) begin
        w_hit = 1'b1;
        w_id  = 4'(i);
      end
    end
  end

  assign w_draw = (r_state == StRun) & ~w_leave & ~hblnk_in & ~vblnk_in & w_hit;

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out   <= '0;
      vcount_out   <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      hblnk_out    <= 1'b0;
      vblnk_out    <= 1'b0;
      rgb_out      <= '0;
      obstacle_x   <= '0;
      obstacle_y   <= '0;
      obstacle_hit <= 1'b0;
      obstacle_id  <= '0;
    end else begin
      hcount_out   <= hcount_in;
      vcount_out   <= vcount_in;
      hsync_out    <= hsync_in;
      vsync_out    <= vsync_in;
      hblnk_out    <= hblnk_in;
      vblnk_out    <= vblnk_in;
      rgb_out      <= w_draw ? COLOR : rgb_in;
      obstacle_x   <= w_draw ? hcount_in : '0;
      obstacle_y   <= w_draw ? vcount_in : '0;
      obstacle_hit <= w_draw;
      obstacle_id  <= w_draw ? w_id : '0;
    end
  end

endmodule
